// File: rtl/bf16_to_mxfp8_packer_if.sv
// Stream bundle for the BF16-to-MXFP8 packer: BF16 input beats and MXFP8 output bytes.
interface bf16_to_mxfp8_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_is_scale;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_is_scale, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_is_scale, out_last
    );
endinterface

// File: rtl/bf16_to_mxfp8_packer.sv
// Collects BLOCK_SIZE BF16 values, then emits one E8M0 shared scale byte followed by
// BLOCK_SIZE E4M3 bytes (round-to-nearest-even, saturating, no subnormals).
module bf16_to_mxfp8_packer #(
    parameter int unsigned BLOCK_SIZE = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   clear,
    bf16_to_mxfp8_packer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {FILL, EMIT_SCALE, EMIT_ELEM} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       emax_q, emax_d;
    logic [7:0]       scale_q, scale_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_is_scale_q, out_is_scale_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      data_buf [BLOCK_SIZE];

    logic             accept_c;
    logic [7:0]       e_in_c;
    logic [7:0]       emax_new_c;
    logic [7:0]       scale_new_c;
    logic [IDX_W-1:0] idx_nxt_c;

    // BF16 -> E4M3 relative to shared scale s
    function automatic logic [7:0] enc(input logic [15:0] x, input logic [7:0] s);
        logic       sign;
        logic [7:0] ex;
        logic [9:0] e;
        logic       inc;
        logic [3:0] man;
        sign = x[15];
        ex   = x[14:7];
        e    = {2'b00, ex} - {2'b00, s} + 10'd7;
        inc  = x[3] & ((|x[2:0]) | x[4]);
        man  = {1'b0, x[6:4]} + {3'b000, inc};
        if (ex == 8'd0) begin
            enc = {sign, 7'h00};
        end else if (ex == 8'hFF) begin
            enc = {sign, 7'h7E};
        end else if ($signed(e) <= 10'sd0) begin
            enc = {sign, 7'h00};
        end else begin
            if (man[3]) begin
                e = e + 10'd1;
            end
            if (($signed(e) > 10'sd15) || ((e == 10'd15) && (man[2:0] == 3'd7))) begin
                enc = {sign, 7'h7E};
            end else begin
                enc = {sign, e[3:0], man[2:0]};
            end
        end
    endfunction

    assign accept_c  = bus.in_valid & in_ready_q;
    assign idx_nxt_c = idx_q + IDX_W'(1);

    // Running block maximum exponent; inf/NaN clamp to 254 so the scale stays finite
    always_comb begin
        e_in_c      = (bus.in_data[14:7] == 8'hFF) ? 8'hFE : bus.in_data[14:7];
        emax_new_c  = (e_in_c > emax_q) ? e_in_c : emax_q;
        scale_new_c = (emax_new_c >= 8'd8) ? (emax_new_c - 8'd8) : 8'd0;
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        idx_d          = idx_q;
        emax_d         = emax_q;
        scale_d        = scale_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_is_scale_d = out_is_scale_q;
        out_last_d     = out_last_q;
        in_ready_d     = in_ready_q;

        if (clear) begin
            state_d        = FILL;
            count_d        = '0;
            idx_d          = '0;
            emax_d         = 8'd0;
            scale_d        = 8'd0;
            out_valid_d    = 1'b0;
            out_data_d     = 8'd0;
            out_is_scale_d = 1'b0;
            out_last_d     = 1'b0;
            in_ready_d     = 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept_c) begin
                        emax_d  = emax_new_c;
                        count_d = count_q + IDX_W'(1);
                        if (count_q == LAST_IDX) begin
                            state_d        = EMIT_SCALE;
                            count_d        = '0;
                            scale_d        = scale_new_c;
                            out_valid_d    = 1'b1;
                            out_data_d     = scale_new_c;
                            out_is_scale_d = 1'b1;
                            out_last_d     = 1'b0;
                            in_ready_d     = 1'b0;
                        end
                    end
                end
                EMIT_SCALE: begin
                    if (bus.out_ready) begin
                        state_d        = EMIT_ELEM;
                        idx_d          = '0;
                        out_data_d     = enc(data_buf[0], scale_q);
                        out_is_scale_d = 1'b0;
                        out_last_d     = 1'b0;
                    end
                end
                EMIT_ELEM: begin
                    if (bus.out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d     = FILL;
                            count_d     = '0;
                            idx_d       = '0;
                            emax_d      = 8'd0;
                            out_valid_d = 1'b0;
                            out_data_d  = 8'd0;
                            out_last_d  = 1'b0;
                            in_ready_d  = 1'b1;
                        end else begin
                            idx_d      = idx_nxt_c;
                            out_data_d = enc(data_buf[idx_nxt_c], scale_q);
                            out_last_d = (idx_nxt_c == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FILL;
            count_q        <= '0;
            idx_q          <= '0;
            emax_q         <= 8'd0;
            scale_q        <= 8'd0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 8'd0;
            out_is_scale_q <= 1'b0;
            out_last_q     <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            emax_q         <= emax_d;
            scale_q        <= scale_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_is_scale_q <= out_is_scale_d;
            out_last_q     <= out_last_d;
            in_ready_q     <= in_ready_d;
        end
    end

    // Element storage needs no reset; it is always rewritten before it is read
    always_ff @(posedge clk) begin
        if (accept_c && !clear) begin
            data_buf[count_q] <= bus.in_data;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_is_scale = out_is_scale_q;
    assign bus.out_last     = out_last_q;
endmodule

// File: tb/tb_bf16_to_mxfp8_packer.sv
// Self-checking bench for bf16_to_mxfp8_packer: directed MX vectors, random blocks
// against an arithmetic reference model, backpressure, clear and mid-block reset.
module tb_bf16_to_mxfp8_packer;
    localparam int BS = 8;
    typedef logic [15:0] blk_t [BS];
    typedef logic [7:0]  exp_t [BS+1];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    bf16_to_mxfp8_packer_if bus();

    bf16_to_mxfp8_packer #(.BLOCK_SIZE(BS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_d [BS+1];
    logic       got_s [BS+1];
    logic       got_l [BS+1];

    // Reference: shared scale from the largest exponent (inf/NaN treated as 254)
    function automatic int model_scale(input blk_t b);
        int emax = 0;
        for (int i = 0; i < BS; i++) begin
            int ev = int'(b[i][14:7]);
            if (ev == 255) ev = 254;
            if (ev > emax) emax = ev;
        end
        return (emax >= 8) ? emax - 8 : 0;
    endfunction

    // Reference: 1.m significand as integer 128..255, rounded to a multiple of 16 (RNE)
    function automatic logic [7:0] model_enc(input logic [15:0] x, input int s);
        int   ex  = int'(x[14:7]);
        int   v   = 128 + int'(x[6:0]);
        int   q;
        int   rem;
        int   e;
        logic sg  = x[15];
        if (ex == 0)   return {sg, 7'h00};
        if (ex == 255) return {sg, 7'h7E};
        e = ex - s + 7;
        if (e <= 0) return {sg, 7'h00};
        q   = v / 16;
        rem = v % 16;
        if (rem > 8 || (rem == 8 && (q % 2) == 1)) q = q + 1;
        if (q == 16) begin
            q = 8;
            e = e + 1;
        end
        if (e > 15 || (e == 15 && q == 15)) return {sg, 7'h7E};
        return {sg, 4'(e), 3'(q - 8)};
    endfunction

    task automatic gen_block(output blk_t b);
        int base = $urandom_range(1, 254);
        for (int i = 0; i < BS; i++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                b[i] = {1'($urandom_range(0, 1)), 15'h0000};
            end else if (r == 1) begin
                b[i] = {1'($urandom_range(0, 1)), 8'hFF, 7'($urandom_range(0, 127))};
            end else if (r == 2) begin
                b[i] = 16'($urandom);
            end else begin
                int ev = base - $urandom_range(0, 12);
                if (ev < 1) ev = 1;
                b[i] = {1'($urandom_range(0, 1)), 8'(ev), 7'($urandom_range(0, 127))};
            end
        end
    endtask

    task automatic push(input logic [15:0] d, input int gap);
        int guard = 0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
    endtask

    task automatic recv(output logic [7:0] d, output logic s, output logic l, input int stall);
        int guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL recv_timeout: out_valid=%b want 1", bus.out_valid);
        end
        repeat (stall) @(negedge clk);
        d = bus.out_data;
        s = bus.out_is_scale;
        l = bus.out_last;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input blk_t b, input int max_gap, input int max_stall);
        for (int i = 0; i < BS; i++) push(b[i], $urandom_range(0, max_gap));
        for (int k = 0; k <= BS; k++) recv(got_d[k], got_s[k], got_l[k], $urandom_range(0, max_stall));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if ({bus.out_data, bus.out_is_scale, bus.out_last} !== 10'd0) begin
            n_err++; $display("FAIL reset_out_fields: got d=%h s=%b l=%b want 0", bus.out_data, bus.out_is_scale, bus.out_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        blk_t dir_in [5];
        exp_t dir_exp [5];
        dir_in[0]  = '{default: 16'h3F80};
        dir_exp[0] = '{8'h77, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
        dir_in[1]  = '{16'h4000, 16'h3F80, 16'hBF80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        dir_exp[1] = '{8'h78, 8'h78, 8'h70, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dir_in[2]  = '{16'h3FF8, 16'h3FC8, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        dir_exp[2] = '{8'h77, 8'h7E, 8'h7C, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
        dir_in[3]  = '{16'h4780, 16'h3F80, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        dir_exp[3] = '{8'h87, 8'h78, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dir_in[4]  = '{16'h7F80, 16'h3F80, 16'hFF80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        dir_exp[4] = '{8'hF6, 8'h7E, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int t = 0; t < 5; t++) begin
            run_block(dir_in[t], 0, 0);
            for (int k = 0; k <= BS; k++) begin
                n_cmp++;
                if ({got_d[k], got_s[k], got_l[k]} !== {dir_exp[t][k], k == 0, k == BS}) begin
                    n_err++;
                    $display("FAIL directed blk%0d beat%0d: got d=%h s=%b l=%b want d=%h s=%b l=%b",
                             t, k, got_d[k], got_s[k], got_l[k], dir_exp[t][k], k == 0, k == BS);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            blk_t b;
            int   sc;
            gen_block(b);
            sc = model_scale(b);
            run_block(b, 2, 2);
            for (int k = 0; k <= BS; k++) begin
                logic [7:0] ed = (k == 0) ? 8'(sc) : model_enc(b[k-1], sc);
                n_cmp++;
                if ({got_d[k], got_s[k], got_l[k]} !== {ed, k == 0, k == BS}) begin
                    n_err++;
                    $display("FAIL random blk%0d beat%0d in=%h: got d=%h s=%b l=%b want d=%h s=%b l=%b",
                             t, k, (k == 0) ? 16'h0 : b[k-1], got_d[k], got_s[k], got_l[k], ed, k == 0, k == BS);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        blk_t b;
        int   sc;
        gen_block(b);
        sc = model_scale(b);
        for (int i = 0; i < BS; i++) push(b[i], 0);
        for (int k = 0; k <= BS; k++) begin
            if (k == 4 || k == BS) begin
                logic [7:0] hd = bus.out_data;
                logic       hl = bus.out_last;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== {1'b1, hd, hl, 1'b0}) begin
                        n_err++;
                        $display("FAIL hold beat%0d cyc%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=0",
                                 k, c, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, hd, hl);
                    end
                end
            end
            recv(got_d[k], got_s[k], got_l[k], 0);
        end
        for (int k = 0; k <= BS; k++) begin
            logic [7:0] ed = (k == 0) ? 8'(sc) : model_enc(b[k-1], sc);
            n_cmp++;
            if ({got_d[k], got_s[k], got_l[k]} !== {ed, k == 0, k == BS}) begin
                n_err++;
                $display("FAIL backpressure beat%0d: got d=%h s=%b l=%b want d=%h s=%b l=%b",
                         k, got_d[k], got_s[k], got_l[k], ed, k == 0, k == BS);
            end
        end
    endtask

    // mode 0: clear mid-FILL; mode 1: clear mid-EMIT_ELEM with out_ready; mode 2: async reset mid-EMIT_ELEM
    task automatic test_abort(input int mode);
        blk_t b;
        int   sc;
        gen_block(b);
        if (mode == 0) begin
            for (int i = 0; i < 3; i++) push(16'h7F00, 0);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
        end else begin
            for (int i = 0; i < BS; i++) push(16'h4780, 0);
            for (int k = 0; k < 3; k++) recv(got_d[k], got_s[k], got_l[k], 0);
            if (mode == 1) begin
                clear = 1'b1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                rst_n = 1'b0;
                #1;
            end
            n_cmp++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL abort%0d_state: got v=%b rdy=%b want v=0 rdy=1", mode, bus.out_valid, bus.in_ready);
            end
            if (mode == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        sc = model_scale(b);
        run_block(b, 1, 1);
        for (int k = 0; k <= BS; k++) begin
            logic [7:0] ed = (k == 0) ? 8'(sc) : model_enc(b[k-1], sc);
            n_cmp++;
            if ({got_d[k], got_s[k], got_l[k]} !== {ed, k == 0, k == BS}) begin
                n_err++;
                $display("FAIL abort%0d_fresh beat%0d: got d=%h s=%b l=%b want d=%h s=%b l=%b",
                         mode, k, got_d[k], got_s[k], got_l[k], ed, k == 0, k == BS);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort(0);
        test_abort(1);
        test_abort(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
